// File: rtl/es_dreq_unit_pkg.sv
// Shared definitions for the EXE-stage data-request unit: ls_type bit indices,
// SRAM size encodings, FSM states and the held request bundle.
package es_dreq_unit_pkg;

    localparam int unsigned LS_WORD  = 0;
    localparam int unsigned LS_BYTE  = 1;
    localparam int unsigned LS_HALF  = 2;
    localparam int unsigned LS_LEFT  = 3;
    localparam int unsigned LS_RIGHT = 4;
    localparam int unsigned LS_UNS   = 5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dreq_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_fields_t;

endpackage

// File: rtl/es_dreq_unit_dreq_align.sv
// Combinational strobe/size/wdata/addr generation for one load/store, from
// the access type, the low address bits and the store source register.
module dreq_align
    import es_dreq_unit_pkg::*;
(
    input  logic        is_store,
    input  logic        is_left,
    input  logic        is_right,
    input  logic        is_half,
    input  logic        is_byte,
    input  logic [31:0] vaddr,
    input  logic [31:0] rt,
    output logic [3:0]  wstrb,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata
);

    logic [1:0] b;
    logic [3:0] strb;

    assign b = vaddr[1:0];

    always_comb begin
        strb  = '0;
        size  = SZ_WORD;
        addr  = vaddr;
        wdata = rt;
        if (is_left) begin
            // ~b == 3-b, so this shifts right by 8*(3-B)
            addr  = {vaddr[31:2], 2'b00};
            wdata = rt >> {~b, 3'b000};
            case (b)
                2'd0:    begin strb = 4'b0001; size = SZ_BYTE; end
                2'd1:    begin strb = 4'b0011; size = SZ_HALF; end
                2'd2:    begin strb = 4'b0111; size = SZ_WORD; end
                default: begin strb = 4'b1111; size = SZ_WORD; end
            endcase
        end else if (is_right) begin
            wdata = rt << {b, 3'b000};
            strb  = 4'b1111 << b;
            case (b)
                2'd0, 2'd1: size = SZ_WORD;
                2'd2:       size = SZ_HALF;
                default:    size = SZ_BYTE;
            endcase
        end else if (is_half) begin
            strb  = b[1] ? 4'b1100 : 4'b0011;
            size  = SZ_HALF;
            wdata = {2{rt[15:0]}};
        end else if (is_byte) begin
            strb  = 4'b0001 << b;
            size  = SZ_BYTE;
            wdata = {4{rt[7:0]}};
        end else begin
            strb  = 4'b1111;
        end
    end

    assign wstrb = is_store ? strb : '0;

endmodule

// File: rtl/es_dreq_unit.sv
// EXE-stage SRAM-like data-request issue unit with in-flight/cancel tracking.
// Define UNALIGNED_LS_EN to support LWL/LWR/SWL/SWR.
module es_dreq_unit
    import es_dreq_unit_pkg::*;
#(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned CNT_W     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_valid,
    input  logic        es_mem_re,
    input  logic [5:0]  es_ls_type,
    input  logic [31:0] es_vaddr,
    input  logic [31:0] es_rt_value,
    input  logic        ms_allowin,
    input  logic        ms_ex,
    input  logic        ws_ex,
    input  logic        exc_flush,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        ms_data_ok,
    output logic        es_mem_ready_go,
    output logic        es_exc_adel_ld,
    output logic        es_exc_ades,
    output logic [1:0]  es_lad
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    dreq_state_e      state;
    dreq_fields_t     hold;
    dreq_fields_t     fields_c;
    dreq_fields_t     fields_o;
    logic [CNT_W-1:0] outst_cnt;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W-1:0] outst_nxt;
    logic             wait_cancel;
    logic             is_left;
    logic             is_right;
    logic             mem_op;
    logic             addr_err;
    logic             issue;
    logic             acc;
    logic             cancel_nz;
    logic             cancel_dec;
    logic             late_cancel;

`ifdef UNALIGNED_LS_EN
    assign is_left  = es_ls_type[LS_LEFT];
    assign is_right = es_ls_type[LS_RIGHT];
    assign mem_op   = es_valid & (|es_ls_type);
`else
    // Unaligned forms degrade to "no memory op" and the shifter folds away
    assign is_left  = 1'b0;
    assign is_right = 1'b0;
    assign mem_op   = es_valid & (|es_ls_type)
                    & ~(es_ls_type[LS_LEFT] | es_ls_type[LS_RIGHT]);
`endif

    assign addr_err = mem_op & ~is_left & ~is_right
                    & ((es_ls_type[LS_HALF] & es_vaddr[0])
                     | (es_ls_type[LS_WORD] & (|es_vaddr[1:0])));

    assign es_exc_adel_ld = addr_err & es_mem_re;
    assign es_exc_ades    = addr_err & ~es_mem_re;
    assign es_lad         = es_vaddr[1:0];

    assign cancel_nz = |cancel_cnt;

    assign issue = mem_op & ~addr_err & ~ms_ex & ~ws_ex & ~exc_flush
                 & ms_allowin & (outst_cnt < MAX_C) & ~cancel_nz;

    dreq_align u_align (
        .is_store (~es_mem_re),
        .is_left  (is_left),
        .is_right (is_right),
        .is_half  (es_ls_type[LS_HALF]),
        .is_byte  (es_ls_type[LS_BYTE]),
        .vaddr    (es_vaddr),
        .rt       (es_rt_value),
        .wstrb    (fields_c.wstrb),
        .size     (fields_c.size),
        .addr     (fields_c.addr),
        .wdata    (fields_c.wdata)
    );
    assign fields_c.wr = ~es_mem_re;

    assign fields_o      = (state == WAIT) ? hold : fields_c;
    assign data_sram_req = (state == WAIT) | ((state == IDLE) & issue);

    assign data_sram_wr    = fields_o.wr;
    assign data_sram_size  = fields_o.size;
    assign data_sram_wstrb = fields_o.wstrb;
    assign data_sram_addr  = fields_o.addr;
    assign data_sram_wdata = fields_o.wdata;

    assign acc         = data_sram_req & data_sram_addr_ok;
    assign cancel_dec  = data_sram_data_ok & cancel_nz;
    assign late_cancel = (state == WAIT) & data_sram_addr_ok & wait_cancel;
    assign outst_nxt   = outst_cnt + CNT_W'(acc) - CNT_W'(data_sram_data_ok);

    assign es_mem_ready_go = ~mem_op | addr_err | ms_ex | ws_ex | acc | (state == DONE);
    assign ms_data_ok      = data_sram_data_ok & ~cancel_nz;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            hold        <= '0;
            wait_cancel <= 1'b0;
            outst_cnt   <= '0;
            cancel_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (issue && !data_sram_addr_ok) begin
                    state <= WAIT;
                    hold  <= fields_c;
                end
                WAIT: if (data_sram_addr_ok) state <= DONE;
                DONE: if (ms_allowin || exc_flush) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A flush seen while still waiting marks the eventual acceptance as dead
            if (state == WAIT) begin
                if (data_sram_addr_ok) wait_cancel <= 1'b0;
                else if (exc_flush)    wait_cancel <= 1'b1;
            end else begin
                wait_cancel <= 1'b0;
            end

            outst_cnt <= outst_nxt;

            if (exc_flush)
                cancel_cnt <= outst_nxt;
            else
                cancel_cnt <= cancel_cnt + CNT_W'(late_cancel) - CNT_W'(cancel_dec);
        end
    end

endmodule

// File: tb/tb_es_dreq_unit.sv
// Directed self-checking bench for es_dreq_unit; expected values hand-computed.
module tb_es_dreq_unit;

    logic        clk;
    logic        resetn;
    logic        es_valid;
    logic        es_mem_re;
    logic [5:0]  es_ls_type;
    logic [31:0] es_vaddr;
    logic [31:0] es_rt_value;
    logic        ms_allowin;
    logic        ms_ex;
    logic        ws_ex;
    logic        exc_flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic        ms_data_ok;
    logic        es_mem_ready_go;
    logic        es_exc_adel_ld;
    logic        es_exc_ades;
    logic [1:0]  es_lad;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    localparam logic [5:0] T_W   = 6'b000001;
    localparam logic [5:0] T_B   = 6'b000010;
    localparam logic [5:0] T_H   = 6'b000100;
    localparam logic [5:0] T_WL  = 6'b001000;
    localparam logic [5:0] T_WR  = 6'b010000;

    es_dreq_unit #(.MAX_OUTST(2), .CNT_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_valid          (es_valid),
        .es_mem_re         (es_mem_re),
        .es_ls_type        (es_ls_type),
        .es_vaddr          (es_vaddr),
        .es_rt_value       (es_rt_value),
        .ms_allowin        (ms_allowin),
        .ms_ex             (ms_ex),
        .ws_ex             (ws_ex),
        .exc_flush         (exc_flush),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .ms_data_ok        (ms_data_ok),
        .es_mem_ready_go   (es_mem_ready_go),
        .es_exc_adel_ld    (es_exc_adel_ld),
        .es_exc_ades       (es_exc_ades),
        .es_lad            (es_lad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic op(input logic v, input logic re, input logic [5:0] t,
                      input logic [31:0] a, input logic [31:0] rt);
        es_valid    = v;
        es_mem_re   = re;
        es_ls_type  = t;
        es_vaddr    = a;
        es_rt_value = rt;
    endtask

    initial begin
        resetn = 1'b0;
        op(1'b0, 1'b0, 6'b0, 32'h0, 32'h0);
        ms_allowin = 1'b1; ms_ex = 1'b0; ws_ex = 1'b0; exc_flush = 1'b0;
        data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
        #2;
        check("rst_req", data_sram_req, 0);
        check("rst_msdok", ms_data_ok, 0);
        check("rst_rdygo", es_mem_ready_go, 1);
        check("rst_outst", dut.outst_cnt, 0);
        check("rst_cancel", dut.cancel_cnt, 0);
        #10 resetn = 1'b1;
        next();

        // 1: SB 0x1003 accepted same cycle
        op(1'b1, 1'b0, T_B, 32'h1003, 32'hAABBCCDD);
        data_sram_addr_ok = 1'b1;
        mid();
        check("t1_req", data_sram_req, 1);
        check("t1_wr", data_sram_wr, 1);
        check("t1_wstrb", data_sram_wstrb, 4'b1000);
        check("t1_wdata", data_sram_wdata, 32'hDDDDDDDD);
        check("t1_size", data_sram_size, 0);
        check("t1_addr", data_sram_addr, 32'h1003);
        check("t1_rdygo", es_mem_ready_go, 1);
        check("t1_lad", es_lad, 2'd3);
        next();
        op(1'b0, 1'b0, 6'b0, 32'h0, 32'h0);
        data_sram_addr_ok = 1'b0;
        mid();
        check("t1_req_drop", data_sram_req, 0);
        check("t1_outst", dut.outst_cnt, 1);
        next();
        data_sram_data_ok = 1'b1;
        mid();
        check("t1_msdok", ms_data_ok, 1);
        next();
        data_sram_data_ok = 1'b0;

        // 2: LW 0x2000, addr_ok delayed, ms_allowin dropped while waiting
        op(1'b1, 1'b1, T_W, 32'h2000, 32'h0);
        mid();
        check("t2_c0_req", data_sram_req, 1);
        check("t2_c0_rdygo", es_mem_ready_go, 0);
        check("t2_c0_wstrb", data_sram_wstrb, 0);
        check("t2_c0_size", data_sram_size, 2);
        next();
        es_vaddr = 32'h2004;
        mid();
        check("t2_c1_req", data_sram_req, 1);
        check("t2_c1_addr", data_sram_addr, 32'h2000);
        check("t2_c1_rdygo", es_mem_ready_go, 0);
        next();
        ms_allowin = 1'b0;
        mid();
        check("t2_c2_req", data_sram_req, 1);
        check("t2_c2_addr", data_sram_addr, 32'h2000);
        check("t2_c2_wr", data_sram_wr, 0);
        check("t2_c2_rdygo", es_mem_ready_go, 0);
        next();
        data_sram_addr_ok = 1'b1;
        mid();
        check("t2_c3_req", data_sram_req, 1);
        check("t2_c3_addr", data_sram_addr, 32'h2000);
        check("t2_c3_rdygo", es_mem_ready_go, 1);
        next();
        data_sram_addr_ok = 1'b0;
        ms_allowin = 1'b1;
        mid();
        check("t2_done_req", data_sram_req, 0);
        check("t2_done_rdygo", es_mem_ready_go, 1);
        next();
        op(1'b0, 1'b0, 6'b0, 32'h0, 32'h0);
        data_sram_data_ok = 1'b1;
        mid();
        check("t2_msdok", ms_data_ok, 1);
        next();
        data_sram_data_ok = 1'b0;

        // 3: misaligned half store / load
        op(1'b1, 1'b0, T_H, 32'h2001, 32'h0);
        mid();
        check("t3_ades", es_exc_ades, 1);
        check("t3_adel_st", es_exc_adel_ld, 0);
        check("t3_req", data_sram_req, 0);
        check("t3_rdygo", es_mem_ready_go, 1);
        next();
        es_mem_re = 1'b1;
        mid();
        check("t3_adel", es_exc_adel_ld, 1);
        check("t3_ades_ld", es_exc_ades, 0);
        next();
        es_valid = 1'b0;
        mid();
        check("t3_adel_inv", es_exc_adel_ld, 0);
        next();

        // 4: two accepted loads, full, flush, both responses cancelled
        op(1'b1, 1'b1, T_W, 32'h100, 32'h0);
        data_sram_addr_ok = 1'b1;
        mid();
        check("t4_a_req", data_sram_req, 1);
        next();
        es_vaddr = 32'h104;
        mid();
        check("t4_b_req", data_sram_req, 1);
        next();
        es_vaddr = 32'h108;
        mid();
        check("t4_full_req", data_sram_req, 0);
        check("t4_full_rdygo", es_mem_ready_go, 0);
        check("t4_outst", dut.outst_cnt, 2);
        next();
        es_valid = 1'b0;
        data_sram_addr_ok = 1'b0;
        exc_flush = 1'b1;
        next();
        exc_flush = 1'b0;
        op(1'b1, 1'b1, T_W, 32'h10C, 32'h0);
        data_sram_data_ok = 1'b1;
        mid();
        check("t4_cancel", dut.cancel_cnt, 2);
        check("t4_dok1", ms_data_ok, 0);
        check("t4_blk_req", data_sram_req, 0);
        next();
        mid();
        check("t4_dok2", ms_data_ok, 0);
        next();
        data_sram_data_ok = 1'b0;
        data_sram_addr_ok = 1'b1;
        mid();
        check("t4_cancel0", dut.cancel_cnt, 0);
        check("t4_c_req", data_sram_req, 1);
        check("t4_c_addr", data_sram_addr, 32'h10C);
        next();
        es_valid = 1'b0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        mid();
        check("t4_dok3", ms_data_ok, 1);
        next();
        data_sram_data_ok = 1'b0;

        // 5: flush while waiting for addr_ok
        op(1'b1, 1'b1, T_W, 32'h200, 32'h0);
        mid();
        check("t5_req", data_sram_req, 1);
        next();
        op(1'b0, 1'b0, 6'b0, 32'h999, 32'h0);
        exc_flush = 1'b1;
        mid();
        check("t5_flush_req", data_sram_req, 1);
        check("t5_flush_addr", data_sram_addr, 32'h200);
        next();
        exc_flush = 1'b0;
        mid();
        check("t5_hold_req", data_sram_req, 1);
        next();
        data_sram_addr_ok = 1'b1;
        mid();
        check("t5_acc_req", data_sram_req, 1);
        next();
        data_sram_addr_ok = 1'b0;
        mid();
        check("t5_done_req", data_sram_req, 0);
        check("t5_cancel", dut.cancel_cnt, 1);
        next();
        data_sram_data_ok = 1'b1;
        mid();
        check("t5_dok", ms_data_ok, 0);
        next();
        data_sram_data_ok = 1'b0;
        mid();
        check("t5_cancel0", dut.cancel_cnt, 0);
        check("t5_outst0", dut.outst_cnt, 0);
        next();

        // 6: unaligned store forms
        op(1'b1, 1'b0, T_WR, 32'h3001, 32'h11223344);
        data_sram_addr_ok = 1'b1;
        mid();
`ifdef UNALIGNED_LS_EN
        check("t6_swr_req", data_sram_req, 1);
        check("t6_swr_wstrb", data_sram_wstrb, 4'b1110);
        check("t6_swr_wdata", data_sram_wdata, 32'h22334400);
        check("t6_swr_size", data_sram_size, 2);
        check("t6_swr_addr", data_sram_addr, 32'h3001);
        check("t6_swr_ades", es_exc_ades, 0);
        next();
        op(1'b1, 1'b0, T_WL, 32'h3002, 32'h11223344);
        mid();
        check("t6_swl_wstrb", data_sram_wstrb, 4'b0111);
        check("t6_swl_wdata", data_sram_wdata, 32'h00112233);
        check("t6_swl_size", data_sram_size, 2);
        check("t6_swl_addr", data_sram_addr, 32'h3000);
`else
        check("t6_swr_req", data_sram_req, 0);
        check("t6_swr_rdygo", es_mem_ready_go, 1);
        check("t6_swr_ades", es_exc_ades, 0);
        next();
        op(1'b1, 1'b0, T_WL, 32'h3002, 32'h11223344);
        mid();
        check("t6_swl_req", data_sram_req, 0);
        check("t6_swl_rdygo", es_mem_ready_go, 1);
`endif
        next();
        op(1'b0, 1'b0, 6'b0, 32'h0, 32'h0);
        data_sram_addr_ok = 1'b0;
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/es_dreq_unit.md
Name: es_dreq_unit

Overview:
- Data-request issue unit in the EXE stage, directly upstream of mem_stage.
- Builds the SRAM-like data request from the EXE-stage load/store fields: req, wr, size, wstrb, addr and wdata.
- Holds `data_sram_req` until `addr_ok`, gates the EXE-stage ready_go, and flags load/store address errors.
- Tracks in-flight requests and filters `data_ok`, so responses belonging to instructions killed by `exc_flush` never reach mem_stage.

Parameters:
- MAX_OUTST, 2, maximum accepted-but-unanswered requests (one in MEM, one leaving EXE).
- CNT_W, 2, width of the outstanding and cancel counters; must hold MAX_OUTST.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- es_valid  in  1  EXE stage holds a valid instruction
- es_mem_re  in  1  instruction is a load
- es_ls_type  in  6  [5] unsigned, [4] LWR/SWR, [3] LWL/SWL, [2] half, [1] byte, [0] word
- es_vaddr  in  32  effective address from the ALU
- es_rt_value  in  32  store source data
- ms_allowin  in  1  mem_stage can accept
- ms_ex  in  1  exception pending in MEM
- ws_ex  in  1  exception pending in WB
- exc_flush  in  1  pipeline flush
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_wstrb  out  4  byte strobes
- data_sram_addr  out  32  request address
- data_sram_wdata  out  32  aligned store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response returned
- ms_data_ok  out  1  filtered data_ok to mem_stage
- es_mem_ready_go  out  1  the memory side of EXE permits the stage to advance
- es_exc_adel_ld  out  1  load address error
- es_exc_ades  out  1  store address error
- es_lad  out  2  `es_vaddr[1:0]`, passed to MEM

Behaviour:
- Reset values (asynchronous, on resetn = 0): state IDLE, `outst_cnt` = 0, `cancel_cnt` = 0, `data_sram_req` = 0, `ms_data_ok` = 0, `es_mem_ready_go` = 1. The address-error flags are combinational and read 0 whenever `es_valid` = 0.
- A memory op is present when `es_valid` is high and `es_ls_type` is nonzero. `wr` = `~es_mem_re`.
- Address error:
  - half access with `vaddr[0]` set;
  - word access with `vaddr[1:0]` nonzero;
  - the error raises `es_exc_adel_ld` for a load and `es_exc_ades` for a store;
  - LWL/LWR/SWL/SWR never raise an address error.
- Issue condition:
  - memory op present, no address error, `ms_ex`, `ws_ex` and `exc_flush` all low;
  - `ms_allowin` high;
  - `outst_cnt` < MAX_OUTST.
- States:
  - IDLE: the issue condition raises `req` combinationally. If `addr_ok` arrives the same cycle, the request is accepted. Otherwise go to WAIT.
  - WAIT: `req` and all request fields are registered and held stable regardless of flush or `ms_allowin`. On `addr_ok`, go to DONE.
  - DONE: accepted; `req` = 0. Return to IDLE when the stage advances (`ms_allowin` high) or on `exc_flush`.
- `es_mem_ready_go` = 1 when any of the following holds: no memory op; an address error; `ms_ex` or `ws_ex`; `addr_ok` in IDLE or WAIT; state DONE.
- Strobes and data. Let B = `vaddr[1:0]`.
  - SW: strobe 1111, size 2.
  - SH: strobe 1100 if `B[1]` else 0011, size 1, wdata = {rt[15:0], rt[15:0]}.
  - SB: strobe = 0001 << B, size 0, wdata = rt[7:0] replicated four times.
  - SWL: strobe = 0001 / 0011 / 0111 / 1111 for B = 0..3; wdata = rt >> 8*(3-B); size = 0 / 1 / 2 / 2; addr = {vaddr[31:2], 2'b00}.
  - SWR: strobe = 1111 / 1110 / 1100 / 1000 for B = 0..3; wdata = rt << 8*B; size = 2 / 2 / 1 / 0; addr = `vaddr`.
  - Loads: strobe 0000. Size and address follow the same rules as the matching store type (LWL as SWL, LWR as SWR).
- Counters:
  - `outst_cnt` increments on `req` & `addr_ok` and decrements on `data_ok`; both in one cycle leaves it unchanged.
  - On `exc_flush`, `cancel_cnt` is loaded with `outst_cnt` + (`req` & `addr_ok`) - `data_ok`.
  - A WAIT-state request that completes `addr_ok` after the flush increments `cancel_cnt` when it is accepted.
  - `ms_data_ok` = `data_ok` & (`cancel_cnt` == 0). While `cancel_cnt` is nonzero, each `data_ok` decrements it.
  - No new issue occurs while `cancel_cnt` is nonzero.

Optional Feature:
- UNALIGNED_LS_EN defined: LWL/LWR/SWL/SWR are handled as specified above.
- Undefined: `es_ls_type[4:3]` are ignored, and such instructions are treated as having no memory op (`ready_go` = 1, no request). The shifter logic for them is removed.

Decomposition:
- Shared package:
  - LS_TYPE bit-index constants;
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding IDLE, WAIT, DONE.
- One sub-module, `dreq_align`: combinational generation of strobe, size, wdata and addr from ls_type, B and rt.

Test Plan:
1. SB, vaddr 0x1003, rt 0xAABBCCDD, `addr_ok` same cycle -> req for one cycle, wstrb 1000, wdata 0xDDDDDDDD, size 0, ready_go = 1 that cycle.
2. LW, vaddr 0x2000, `addr_ok` delayed 3 cycles, `ms_allowin` dropped in cycle 2 -> req and fields held stable throughout; ready_go is 0 until `addr_ok`, then 1.
3. SH to 0x2001 -> `es_exc_ades` = 1, no req, ready_go = 1; the same address for LH raises `es_exc_adel_ld`.
4. Two LWs accepted, `exc_flush` before any `data_ok` -> `cancel_cnt` = 2; the next two `data_ok` pulses give `ms_data_ok` = 0; a third request then issues normally.
5. `exc_flush` while in WAIT, `addr_ok` 2 cycles later -> request is counted as cancelled, and its `data_ok` is suppressed.
6. SWR, vaddr 0x3001, rt 0x11223344 -> wstrb 1110, wdata 0x22334400, size 2. With UNALIGNED_LS_EN undefined -> no req, ready_go = 1.
